fir_tap_sequencer: RTL and testbench



---
 rtl/fir_tap_sequencer_pkg.sv | 22 ++
 rtl/fir_tap_sequencer_booth_mult.sv | 30 +++
 rtl/fir_tap_sequencer.sv | 112 +++++++++++
 tb/tb_fir_tap_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_tap_sequencer_pkg.sv
// Shared operand width, FSM state encoding and accumulator width helper
// for the time-multiplexed FIR tap sequencer.
`ifndef OPERAND_SIZE
`define OPERAND_SIZE 8
`endif

package fir_tap_sequencer_pkg;

  localparam int OPERAND_SIZE = `OPERAND_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Guard bits let TAPS full-scale products accumulate without overflow.
  function automatic int acc_width(input int w, input int taps);
    return 2 * w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_booth_mult.sv
// Combinational radix-2 Booth multiplier producing the full 2W-bit
// two's-complement product.
module fir_tap_sequencer_booth_mult #(
  parameter int W = 8
) (
  input  logic signed [W-1:0]   multiplicand,
  input  logic signed [W-1:0]   multiplier,
  output logic signed [2*W-1:0] product
);

  logic signed [2*W-1:0] mcand_ext;
  logic                  prev;

  assign mcand_ext = {{W{multiplicand[W-1]}}, multiplicand};

  // Scan multiplier bit pairs, adding or subtracting the shifted multiplicand.
  always_comb begin
    product = '0;
    prev    = 1'b0;
    for (int i = 0; i < W; i++) begin
      case ({multiplier[i], prev})
        2'b01:   product = product + (mcand_ext <<< i);
        2'b10:   product = product - (mcand_ext <<< i);
        default: product = product;
      endcase
      prev = multiplier[i];
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Direct-form FIR controller sharing one multiplier across all taps:
// one MAC per cycle, TAPS cycles per output sample.
module fir_tap_sequencer
  import fir_tap_sequencer_pkg::*;
#(
  parameter int W     = OPERAND_SIZE,
  parameter int TAPS  = 3,
  parameter int ACC_W = acc_width(W, TAPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [$clog2(TAPS)-1:0]   cfg_addr,
  input  logic signed [W-1:0]       cfg_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [W-1:0]       x,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic signed [ACC_W-1:0]   y,
  output logic                      busy
);

  localparam int KW = $clog2(TAPS);

  state_t                  state;
  state_t                  next_state;
  logic signed [W-1:0]     coef [TAPS];
  logic signed [W-1:0]     d    [TAPS];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [2*W-1:0]   prod;
  logic [KW-1:0]           k;
  logic                    accept;
  logic                    last;

  fir_tap_sequencer_booth_mult #(.W(W)) u_mult (
    .multiplicand (d[k]),
    .multiplier   (coef[k]),
    .product      (prod)
  );

  assign accept  = (state == IDLE) && in_valid && in_ready;
  assign last    = (k == KW'(TAPS - 1));
  assign sum     = acc + {{(ACC_W - 2 * W){prod[2*W-1]}}, prod};
  assign y_valid = (state == DONE);
  assign busy    = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = MAC;
        else        next_state = IDLE;
      end
      MAC: begin
        if (last) next_state = DONE;
        else      next_state = MAC;
      end
      DONE: begin
        if (y_ready) next_state = IDLE;
        else         next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Coefficient file, delay line, accumulator and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < TAPS; j++) begin
        coef[j] <= '0;
        d[j]    <= '0;
      end
      acc      <= '0;
      k        <= '0;
      y        <= '0;
      in_ready <= 1'b0;
    end else begin
      in_ready <= (next_state == IDLE);
      // Writes outside IDLE are dropped so a computation sees fixed taps.
      if ((state == IDLE) && cfg_we && (int'(cfg_addr) < TAPS)) begin
        coef[cfg_addr] <= cfg_data;
      end
      if (accept) begin
        d[0] <= x;
        for (int j = 1; j < TAPS; j++) begin
          d[j] <= d[j-1];
        end
        acc <= '0;
        k   <= '0;
      end else if (state == MAC) begin
        acc <= sum;
        k   <= k + KW'(1);
        if (last) begin
          y <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed and randomized self-checking bench for fir_tap_sequencer
// (W=8, TAPS=3, ACC_W=18).
module tb_fir_tap_sequencer;

  logic               clk;
  logic               rst;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic signed [7:0]  cfg_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  x;
  logic               y_valid;
  logic               y_ready;
  logic signed [17:0] y;
  logic               busy;

  int checks = 0;
  int errors = 0;

  fir_tap_sequencer #(.W(8), .TAPS(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y        (y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic signed [7:0] dat);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = dat;
    step();
    cfg_we   = 1'b0;
  endtask

  // cw: 0 no write, 1 write on the handshake edge, 2 write during first MAC cycle
  task automatic send(input logic signed [7:0] s, input int stall, input int cw,
                      input logic [1:0] ca, input logic signed [7:0] cd,
                      output logic signed [17:0] res, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("in_ready_before_send", 64'(in_ready), 64'sd1);
    x        = s;
    in_valid = 1'b1;
    if (cw == 1) begin
      cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
    end
    step();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    if (cw == 2) begin
      cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
    end
    lat = 0;
    while (!y_valid && lat < 20) begin
      step();
      lat++;
      cfg_we = 1'b0;
    end
    res = y;
    repeat (stall) step();
    y_ready = 1'b1;
    step();
    y_ready = 1'b0;
  endtask

  initial begin
    logic signed [17:0] res;
    int                 lat;
    int                 imp_s [4] = '{1, 0, 0, 0};
    int                 imp_e [4] = '{1, 2, 3, 0};
    int                 cm [3];
    int                 hm [3];
    int                 sum;
    logic signed [7:0]  rs;
    logic signed [7:0]  rd;
    logic [1:0]         ra;
    int                 rcw;

    clk = 1'b0; rst = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'sd0;
    in_valid = 1'b0; x = 8'sd0; y_ready = 1'b0;
    #2 rst = 1'b1;
    step();
    step();
    chk("rst_y_valid", 64'(y_valid), 64'sd0);
    chk("rst_y", 64'(y), 64'sd0);
    chk("rst_busy", 64'(busy), 64'sd0);
    chk("rst_in_ready", 64'(in_ready), 64'sd0);
    rst = 1'b0;
    step();
    chk("in_ready_after_rst", 64'(in_ready), 64'sd1);

    // Impulse response
    cfg_write(2'd0, 8'sd1);
    cfg_write(2'd1, 8'sd2);
    cfg_write(2'd2, 8'sd3);
    for (int i = 0; i < 4; i++) begin
      send(8'(imp_s[i]), 0, 0, 2'd0, 8'sd0, res, lat);
      chk("impulse_y", 64'(res), 64'(imp_e[i]));
      chk("impulse_latency", 64'(lat), 64'sd3);
    end

    // Signed extreme
    for (int i = 0; i < 3; i++) cfg_write(2'(i), -8'sd128);
    for (int i = 0; i < 3; i++) begin
      send(-8'sd128, 0, 0, 2'd0, 8'sd0, res, lat);
      chk("extreme_y", 64'(res), 64'(16384 * (i + 1)));
    end

    // Backpressure: d becomes {1,-128,-128} -> -128 + 16384 + 16384
    x = 8'sd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!y_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'sd3);
    chk("bp_y", 64'(y), 64'sd32640);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; x = 8'sd99;
      step();
      chk("bp_y_stable", 64'(y), 64'sd32640);
      chk("bp_y_valid_held", 64'(y_valid), 64'sd1);
      chk("bp_in_ready_low", 64'(in_ready), 64'sd0);
      chk("bp_busy", 64'(busy), 64'sd1);
    end
    in_valid = 1'b0; y_ready = 1'b1;
    step();
    y_ready = 1'b0;
    chk("bp_y_valid_drop", 64'(y_valid), 64'sd0);
    chk("bp_y_hold", 64'(y), 64'sd32640);

    // Config while busy; 99 must not have entered the delay line
    cfg_write(2'd0, 8'sd1);
    cfg_write(2'd1, 8'sd2);
    cfg_write(2'd2, 8'sd3);
    send(8'sd2, 0, 2, 2'd1, 8'sd5, res, lat);
    chk("busy_cfg_current", 64'(res), -64'sd380);
    send(8'sd6, 0, 0, 2'd0, 8'sd0, res, lat);
    chk("busy_cfg_next", 64'(res), 64'sd13);
    cfg_write(2'd3, 8'sd77);
    send(8'sd0, 1, 1, 2'd1, 8'sd5, res, lat);
    chk("idle_cfg_simultaneous", 64'(res), 64'sd36);

    // Reset on the second MAC cycle
    x = 8'sd9; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_y_valid", 64'(y_valid), 64'sd0);
    chk("midrst_busy", 64'(busy), 64'sd0);
    chk("midrst_y", 64'(y), 64'sd0);
    step();
    step();
    rst = 1'b0;
    send(8'sd7, 0, 0, 2'd0, 8'sd0, res, lat);
    chk("postrst_coef_cleared", 64'(res), 64'sd0);
    for (int i = 0; i < 3; i++) cfg_write(2'(i), 8'sd1);
    send(8'sd0, 0, 0, 2'd0, 8'sd0, res, lat);
    chk("postrst_delay_1", 64'(res), 64'sd7);
    send(8'sd0, 0, 0, 2'd0, 8'sd0, res, lat);
    chk("postrst_delay_2", 64'(res), 64'sd7);

    // Random regression against a golden model
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cm[i] = 0;
      hm[i] = 0;
    end
    for (int n = 0; n < 1000; n++) begin
      rs  = 8'($urandom);
      rd  = 8'($urandom);
      ra  = 2'($urandom_range(0, 3));
      rcw = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if (rcw == 1 && ra < 2'd3) cm[ra] = rd;
      hm[2] = hm[1];
      hm[1] = hm[0];
      hm[0] = rs;
      sum = cm[0] * hm[0] + cm[1] * hm[1] + cm[2] * hm[2];
      send(rs, $urandom_range(0, 2), rcw, ra, rd, res, lat);
      chk("random_y", 64'(res), 64'(sum));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
